// File: rtl/adder_seq_ctrl.sv
// Operand-entry and result sequencer for the 4-bit adder demo: capture A, capture B, latch sum, show.
// Optional subtract mode is enabled by defining ADDER_SUB_EN (adds the mode input).
module adder_seq_ctrl #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             clear,
`ifdef ADDER_SUB_EN
  input  logic             mode,
`endif
  input  logic [WIDTH-1:0] val,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             cout_in,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             cin,
  output logic [WIDTH-1:0] led,
  output logic             led_carry,
  output logic [1:0]       state_o,
  output logic             busy
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    CALC    = 2'b10,
    SHOW    = 2'b11
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             step_q_reg;
  logic [WIDTH-1:0] op_a_reg, op_a_next;
  logic [WIDTH-1:0] op_b_reg, op_b_next;
  logic [WIDTH-1:0] res_reg, res_next;
  logic             res_c_reg, res_c_next;
  logic             mode_reg, mode_next;
  logic             mode_in;
  logic [WIDTH-1:0] b_val;
  logic             step_rise;

`ifdef ADDER_SUB_EN
  assign mode_in = mode;
`else
  assign mode_in = 1'b0;
`endif

  // In subtract mode B is stored inverted so the adder sees A + ~B + 1.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_binv
    assign b_val[gi] = val[gi] ^ mode_in;
  end

  assign step_rise = step & ~step_q_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ENTER_A;
      cnt_reg    <= '0;
      step_q_reg <= 1'b1;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      res_reg    <= '0;
      res_c_reg  <= 1'b0;
      mode_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      step_q_reg <= step;
      op_a_reg   <= op_a_next;
      op_b_reg   <= op_b_next;
      res_reg    <= res_next;
      res_c_reg  <= res_c_next;
      mode_reg   <= mode_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_a_next  = op_a_reg;
    op_b_next  = op_b_reg;
    res_next   = res_reg;
    res_c_next = res_c_reg;
    mode_next  = mode_reg;
    if (clear) begin
      state_next = ENTER_A;
      cnt_next   = '0;
    end else begin
      unique case (state_reg)
        ENTER_A: begin
          if (step_rise) begin
            op_a_next  = val;
            state_next = ENTER_B;
          end
        end
        ENTER_B: begin
          if (step_rise) begin
            op_b_next  = b_val;
            mode_next  = mode_in;
            state_next = CALC;
          end
        end
        CALC: begin
          res_next   = sum_in;
          res_c_next = cout_in;
          cnt_next   = '0;
          state_next = SHOW;
        end
        SHOW: begin
          // Leaving SHOW on a press does not capture A; a fresh press is needed.
          if (step_rise || cnt_reg == LAST_CNT) begin
            state_next = ENTER_A;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        default: state_next = ENTER_A;
      endcase
    end
  end

  assign op_a      = op_a_reg;
  assign op_b      = op_b_reg;
  assign cin       = mode_reg;
  assign led       = (state_reg == SHOW) ? res_reg : val;
  assign led_carry = (state_reg == SHOW) & res_c_reg;
  assign state_o   = state_reg;
  assign busy      = (state_reg == CALC);

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Randomized self-checking bench for adder_seq_ctrl against a transaction-level model.
// Drives directed test-plan sequences, then random button/clear/reset activity.
module tb_adder_seq_ctrl;

  localparam int W    = 4;
  localparam int HOLD = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset, step, clear, mode;
  logic [W-1:0] val, sum_in, op_a, op_b, led;
  logic         cout_in, cin, led_carry, busy;
  logic [1:0]   state_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase 0..3 = A entry, B entry, compute, showing.
  int m_phase, m_a, m_b_raw, m_b_reg, m_cin, m_res, m_resc, m_shown, m_prev_step;

  always #5 clk = ~clk;

  // External combinational adder
  assign {cout_in, sum_in} = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, cin};

  adder_seq_ctrl #(.WIDTH(W), .HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .clear     (clear),
`ifdef ADDER_SUB_EN
    .mode      (mode),
`endif
    .val       (val),
    .sum_in    (sum_in),
    .cout_in   (cout_in),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .led       (led),
    .led_carry (led_carry),
    .state_o   (state_o),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    m_phase = 0; m_a = 0; m_b_raw = 0; m_b_reg = 0; m_cin = 0;
    m_res = 0; m_resc = 0; m_shown = 0; m_prev_step = 1;
  endtask

  // One clock: apply inputs at the falling edge, check outputs, then advance the model.
  task automatic cyc(input logic r, input logic s, input logic c, input int v, input logic md);
    bit rise;
    bit sub;
    reset = r; step = s; clear = c; val = W'(v); mode = md;
    #1;
    check("state_o", 32'(state_o), 32'(m_phase));
    check("busy", 32'(busy), 32'(m_phase == 2));
    check("op_a", 32'(op_a), 32'(m_a));
    check("op_b", 32'(op_b), 32'(m_b_reg));
    check("cin", 32'(cin), 32'(m_cin));
    check("led", 32'(led), (m_phase == 3) ? 32'(m_res) : 32'(v & MASK));
    check("led_carry", 32'(led_carry), (m_phase == 3) ? 32'(m_resc) : 32'd0);
`ifdef ADDER_SUB_EN
    sub = md;
`else
    sub = 1'b0;
`endif
    if (r) begin
      model_reset();
    end else begin
      rise = s && !m_prev_step;
      m_prev_step = s;
      if (c) begin
        m_phase = 0;
        m_shown = 0;
      end else if (m_phase == 0) begin
        if (rise) begin m_a = v & MASK; m_phase = 1; end
      end else if (m_phase == 1) begin
        if (rise) begin
          m_b_raw = v & MASK;
          m_b_reg = sub ? (~v & MASK) : (v & MASK);
          m_cin   = sub;
          m_phase = 2;
        end
      end else if (m_phase == 2) begin
        if (m_cin == 1) begin
          m_res  = (m_a - m_b_raw) & MASK;
          m_resc = (m_a >= m_b_raw);
        end else begin
          m_res  = (m_a + m_b_raw) & MASK;
          m_resc = (m_a + m_b_raw) > MASK;
        end
        m_shown = 0;
        m_phase = 3;
      end else begin
        m_shown++;
        if (rise || m_shown == HOLD) begin m_phase = 0; m_shown = 0; end
      end
    end
    @(negedge clk);
  endtask

  task automatic press(input int v, input logic md);
    cyc(0, 1, 0, v, md);
    cyc(0, 0, 0, v, md);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, $urandom_range(0, MASK), 0);
  endtask

  initial begin
    reset = 1; step = 1; clear = 0; val = '0; mode = 0;
    @(negedge clk);
    @(negedge clk);
    model_reset();

    // Reset with step held, release: no capture until a new press
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 6, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 6, 0);
    cyc(0, 0, 0, 6, 0);
    press(5, 0); press(3, 0); idle(HOLD + 4);
    // Overflow, then auto-return after the full hold time
    press(15, 0); press(1, 0); idle(HOLD + 4);
    // Early exit from SHOW by a press
    press(9, 0); press(4, 0); idle(4); press(2, 0); idle(3);
    // Clear in ENTER_B, in SHOW, and clear together with a press in ENTER_A
    press(2, 0); cyc(0, 0, 1, 2, 0); idle(2);
    press(6, 0); press(7, 0); idle(3); cyc(0, 0, 1, 0, 0); idle(2);
    cyc(0, 1, 1, 11, 0); idle(2);
    // Subtract mode (mode ignored when the option is not built)
    press(7, 1); press(2, 1); idle(3);
    press(2, 1); press(7, 1); idle(HOLD + 3);

    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 59) == 0), $urandom_range(0, MASK), 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
